// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one outstanding 32-bit word transfer,
// all APB outputs registered, PREADY timeout aborts with an AHB ERROR response.
module ahb_apb_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [31:0]               HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [31:0]               HRDATA,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [31:0]               PWDATA,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               hrdata_q, hrdata_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      accept;
    logic                      unused_ok;

    // Only the ready states sample the address phase; BUSY and IDLE are ignored.
    assign accept = (state_q inside {S_IDLE, S_DONE, S_ERR2}) & HSEL & HREADY & HTRANS[1];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        hrdata_d = hrdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;

        unique case (state_q)
            S_WDATA: begin
                pwdata_d = HWDATA;
                state_d  = S_SETUP;
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? S_ERR1 : S_DONE;
                    if (!write_q) hrdata_d = PRDATA;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            addr_d  = HADDR[APB_ADDR_WIDTH-1:0];
            write_d = HWRITE;
            if (HSIZE != 3'b010) state_d = S_ERR1;
            else if (HWRITE)     state_d = S_WDATA;
            else                 state_d = S_SETUP;
        end

        // A read enters SETUP straight from the address phase, so bypass the latch.
        if (state_d == S_SETUP) begin
            cnt_d    = '0;
            paddr_d  = accept ? HADDR[APB_ADDR_WIDTH-1:0] : addr_q;
            pwrite_d = accept ? HWRITE : write_q;
        end

        psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d = (state_d == S_ACCESS);
    end

    // NOTE: sequential state uses non-blocking assignments; all registers are
    // small control/data flops, so every one of them is reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            cnt_q     <= '0;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            cnt_q     <= cnt_d;
            hrdata_q  <= hrdata_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign HREADYOUT = state_q inside {S_IDLE, S_DONE, S_ERR2};
    assign HRESP     = state_q inside {S_ERR1, S_ERR2};
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

    assign unused_ok = ^{HADDR[31:APB_ADDR_WIDTH], HTRANS[0]};
endmodule
